// File: rtl/test_i2441.sv
// rtl/test_i2441.sv - bit-serial pattern detector with overlap and fill guard
module test_i2441 #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
    input  logic N,
    input  logic CK,
    input  logic reset,
    output logic output_single
);

    localparam int               FW       = $clog2(PAT_LEN);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_LEN - 1);

    generate
        if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
            $error("test_i2441: PAT_LEN must be in 2..16");
        end
    endgenerate

    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               out_q, out_d;
    logic [PAT_LEN-1:0] window;

    // The fill guard keeps the zero-cleared history from matching a pattern with leading zeros.
    always_comb begin
        window = {hist_q, N};
        hist_d = window[PAT_LEN-2:0];
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
        out_d  = (fill_q == FILL_MAX) && (window == PATTERN);
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    assign output_single = out_q;

endmodule

// File: tb/tb_test_i2441.sv
// tb/tb_test_i2441.sv - table-driven and randomized checks for test_i2441
module tb_test_i2441;

    logic CK = 1'b0;
    logic N = 1'b0;
    logic reset = 1'b1;
    logic out_a, out_b;

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    test_i2441 #(.PAT_LEN(4), .PATTERN(4'b1011)) dut_a (
        .N(N), .CK(CK), .reset(reset), .output_single(out_a)
    );
    test_i2441 #(.PAT_LEN(4), .PATTERN(4'b0000)) dut_b (
        .N(N), .CK(CK), .reset(reset), .output_single(out_b)
    );

    typedef struct {
        bit rst;
        bit n;
        bit exp_a;
        bit exp_b;
    } vec_t;

    vec_t vecs[$];

    // Reference: every bit received since reset, matched against the pattern tail.
    bit hist[$];

    function automatic bit model_match(input logic [3:0] pat);
        if (hist.size() < 4) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (hist[hist.size() - 4 + i] != pat[3 - i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add(input bit r, input bit n, input bit ea, input bit eb);
        vec_t v;
        v.rst = r; v.n = n; v.exp_a = ea; v.exp_b = eb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit n);
        reset = r;
        N = n;
        @(posedge CK);
        #1;
        if (r) hist.delete();
        else begin
            hist.push_back(n);
            if (hist.size() > 16) void'(hist.pop_front());
        end
    endtask

    initial begin
        // Reset held two edges with N toggling, then 1,0,1,1,0
        add(1, 1, 0, 0); add(1, 0, 0, 0);
        add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 0);
        add(0, 0, 0, 0);
        // Overlapping matches
        add(1, 0, 0, 0);
        add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 0);
        add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 0); add(0, 0, 0, 0);
        // Fill guard on all-zero pattern
        add(1, 0, 0, 0);
        add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0);
        add(0, 0, 0, 1); add(0, 0, 0, 1); add(0, 0, 0, 1);
        add(0, 1, 0, 0); add(0, 0, 0, 0);
        // Reset mid-sequence discards history
        add(1, 0, 0, 0);
        add(0, 1, 0, 0); add(0, 0, 0, 0);
        add(1, 1, 0, 0);
        add(0, 1, 0, 0); add(0, 1, 0, 0);
        add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 0);
        // Constant ones then constant zeros
        add(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, (i >= 3) ? 1'b1 : 1'b0);

        step(1, 0);
        check("reset_a", -1, out_a, 1'b0);
        check("reset_b", -1, out_b, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].n);
            check("table_a", i, out_a, vecs[i].exp_a);
            check("table_b", i, out_b, vecs[i].exp_b);
            check("model_a", i, out_a, model_match(4'b1011));
            check("model_b", i, out_b, model_match(4'b0000));
        end

        for (int i = 0; i < 3000; i++) begin
            bit r, n;
            r = ($urandom_range(0, 31) == 0);
            n = (i % 500 < 100) ? 1'b0 : 1'($urandom);
            step(r, n);
            check("rand_a", i, out_a, model_match(4'b1011));
            check("rand_b", i, out_b, model_match(4'b0000));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
